bus_memory_responder: RTL and testbench



---
 rtl/bus_memory_responder_pkg.sv | 23 ++
 rtl/bus_ram.sv | 42 ++++
 rtl/bus_memory_responder.sv | 163 ++++++++++++++++
 tb/tb_bus_memory_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_memory_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bus_memory_responder_pkg
// Description : Shared definitions for CPU6 external-bus target responders:
//               the responder state encoding and the default value returned
//               by reads that fall outside any mapped memory.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bus_memory_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } bus_state_e;

   localparam logic [7:0] UNMAPPED_DATA_DEFAULT = 8'hFF;

   localparam int WAIT_COUNT_BITS = 4;

endpackage : bus_memory_responder_pkg
`default_nettype wire

// File: rtl/bus_ram.sv
`default_nettype none
// ============================================================================
// Module      : bus_ram
// Description : Single-port synchronous byte RAM with a registered read port.
//               Read data appears after the edge at which re is sampled high
//               and holds until the next read. Contents are never cleared.
// Ports       : clock  - rising-edge clock
//               we     - write enable (writes wdata to addr at the edge)
//               re     - read enable (captures mem[addr] into rdata)
//               addr   - word index
//               wdata  - write data
//               rdata  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module bus_ram #(
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = 12
) (
   input  logic              clock,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule : bus_ram
`default_nettype wire

// File: rtl/bus_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_memory_responder
// Description : CPU6 external-bus target that serves read/write cycles from
//               on-chip RAM with WAIT_STATES programmable wait cycles and a
//               registered ready handshake. Unmapped reads return
//               UNMAPPED_DATA, unmapped writes are dropped, and both strobes
//               high in IDLE raises a one-cycle busError pulse.
// Ports       : clock       - rising-edge clock shared with CPU6
//               reset       - synchronous active-high reset
//               addressBus  - address from CPU6
//               dataBusIn   - write data from CPU6
//               dataBusOut  - read data (registered)
//               dataBusOE   - high while the responder drives dataBus
//               readStrobe  - read request, level, held until ready
//               writeStrobe - write request, level, held until ready
//               ready       - cycle complete (registered)
//               busError    - one-cycle pulse on illegal strobe combination
// Revision    : 1.0 - initial release
// ============================================================================
module bus_memory_responder
   import bus_memory_responder_pkg::*;
#(
   parameter int         ADDR_BITS     = 16,
   parameter int         RAM_DEPTH     = 4096,
   parameter int         WAIT_STATES   = 1,
   parameter logic [7:0] UNMAPPED_DATA = UNMAPPED_DATA_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [ADDR_BITS-1:0] addressBus,
   input  logic [7:0]           dataBusIn,
   output logic [7:0]           dataBusOut,
   output logic                 dataBusOE,
   input  logic                 readStrobe,
   input  logic                 writeStrobe,
   output logic                 ready,
   output logic                 busError
);

   localparam int IDX_BITS = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam logic [WAIT_COUNT_BITS-1:0] WAIT_LOAD = WAIT_COUNT_BITS'(WAIT_STATES);

   bus_state_e                 state_q,     state_d;
   logic [WAIT_COUNT_BITS-1:0] count_q,     count_d;
   logic [ADDR_BITS-1:0]       addr_q,      addr_d;
   logic [7:0]                 wdata_q,     wdata_d;
   logic                       is_write_q,  is_write_d;
   logic                       ready_q,     ready_d;
   logic                       oe_q,        oe_d;
   logic                       bus_error_q, bus_error_d;

   logic       mapped;
   logic       access_now;
   logic       latched_strobe;
   logic       ram_we;
   logic       ram_re;
   logic [7:0] ram_rdata;

   // Mapped when every address bit above the RAM index is zero.
   assign mapped = ((addr_q >> IDX_BITS) == '0);

   // The access edge is the WAIT edge with the counter exhausted. The RAM
   // read is enabled during the cycle leading into that edge so its
   // registered output lands together with ready.
   assign access_now = (state_q == ST_WAIT) && (count_q == '0);

   // A reset coinciding with the access edge discards the write.
   assign ram_we = access_now && is_write_q && mapped && !reset;
   assign ram_re = access_now && !is_write_q && mapped;

   // Only the strobe matching the latched direction ends the cycle.
   assign latched_strobe = is_write_q ? writeStrobe : readStrobe;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      is_write_d  = is_write_q;
      ready_d     = ready_q;
      oe_d        = oe_q;
      bus_error_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (readStrobe && writeStrobe) begin
               bus_error_d = 1'b1;
            end else if (readStrobe || writeStrobe) begin
               addr_d     = addressBus;
               wdata_d    = dataBusIn;
               is_write_d = writeStrobe;
               count_d    = WAIT_LOAD;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (count_q != '0) begin
               count_d = count_q - 1'b1;
            end else begin
               state_d = ST_DONE;
               ready_d = 1'b1;
               oe_d    = !is_write_q;
            end
         end
         ST_DONE: begin
            if (!latched_strobe) begin
               ready_d = 1'b0;
               oe_d    = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ready_d = 1'b0;
            oe_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         is_write_q  <= 1'b0;
         ready_q     <= 1'b0;
         oe_q        <= 1'b0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         is_write_q  <= is_write_d;
         ready_q     <= ready_d;
         oe_q        <= oe_d;
         bus_error_q <= bus_error_d;
      end
   end

   bus_ram #(
      .DEPTH  (RAM_DEPTH),
      .ADDR_W (IDX_BITS)
   ) u_ram (
      .clock (clock),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (addr_q[IDX_BITS-1:0]),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // Both mux inputs are registered and stable while oe_q is high; the
   // output reads zero whenever the bus is not driven.
   assign dataBusOut = oe_q ? (mapped ? ram_rdata : UNMAPPED_DATA) : 8'h00;
   assign dataBusOE  = oe_q;
   assign ready      = ready_q;
   assign busError   = bus_error_q;

endmodule : bus_memory_responder
`default_nettype wire

// File: tb/tb_bus_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_memory_responder
// Description : Directed self-checking bench for bus_memory_responder. Three
//               instances (WAIT_STATES = 1, 0, 15) share the bus stimulus;
//               functional checks use the WAIT_STATES=1 instance, latency
//               checks use all three.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_memory_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] addressBus = 16'h0000;
   logic [7:0]  dataBusIn = 8'h00;
   logic        readStrobe = 1'b0;
   logic        writeStrobe = 1'b0;

   logic [7:0] dataBusOut1, dataBusOut0, dataBusOut15;
   logic       dataBusOE1, dataBusOE0, dataBusOE15;
   logic       ready1, ready0, ready15;
   logic       busError1, busError0, busError15;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   bus_memory_responder #(.ADDR_BITS(16), .RAM_DEPTH(4096), .WAIT_STATES(1)) dut1 (
      .clock(clock), .reset(reset), .addressBus(addressBus), .dataBusIn(dataBusIn),
      .dataBusOut(dataBusOut1), .dataBusOE(dataBusOE1), .readStrobe(readStrobe),
      .writeStrobe(writeStrobe), .ready(ready1), .busError(busError1));

   bus_memory_responder #(.ADDR_BITS(16), .RAM_DEPTH(4096), .WAIT_STATES(0)) dut0 (
      .clock(clock), .reset(reset), .addressBus(addressBus), .dataBusIn(dataBusIn),
      .dataBusOut(dataBusOut0), .dataBusOE(dataBusOE0), .readStrobe(readStrobe),
      .writeStrobe(writeStrobe), .ready(ready0), .busError(busError0));

   bus_memory_responder #(.ADDR_BITS(16), .RAM_DEPTH(4096), .WAIT_STATES(15)) dut15 (
      .clock(clock), .reset(reset), .addressBus(addressBus), .dataBusIn(dataBusIn),
      .dataBusOut(dataBusOut15), .dataBusOE(dataBusOE15), .readStrobe(readStrobe),
      .writeStrobe(writeStrobe), .ready(ready15), .busError(busError15));

   // Full bus cycle on dut1. Address/data are scrambled right after the
   // sampling edge so a design that fails to latch them is exposed.
   task automatic run_cycle(input logic wr, input logic [15:0] a, input logic [7:0] d,
                            output int lat, output logic [7:0] rd, output logic oe_r,
                            output logic rdy_hold, output logic [7:0] rd_hold,
                            output logic rdy_after, output logic oe_after);
      @(negedge clock);
      addressBus  = a;
      dataBusIn   = d;
      readStrobe  = !wr;
      writeStrobe = wr;
      @(posedge clock);
      #1;
      addressBus = ~a;
      dataBusIn  = ~d;
      lat = 0;
      do begin
         @(posedge clock);
         lat++;
         #1;
      end while (!ready1 && lat < 40);
      rd   = dataBusOut1;
      oe_r = dataBusOE1;
      @(posedge clock);
      #1;
      rdy_hold = ready1;
      rd_hold  = dataBusOut1;
      @(negedge clock);
      readStrobe  = 1'b0;
      writeStrobe = 1'b0;
      @(posedge clock);
      #1;
      rdy_after = ready1;
      oe_after  = dataBusOE1;
   endtask

   task automatic idle(input int n);
      @(negedge clock);
      readStrobe  = 1'b0;
      writeStrobe = 1'b0;
      repeat (n) @(posedge clock);
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset      = 1'b1;
      readStrobe = 1'b1;
      addressBus = 16'h0010;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         tests_run++;
         if (ready1 !== 1'b0 || dataBusOE1 !== 1'b0 || busError1 !== 1'b0 || dataBusOut1 !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_cycle%0d: ready=%b oe=%b err=%b out=%h, required 0 0 0 00",
                     i, ready1, dataBusOE1, busError1, dataBusOut1);
         end
      end
      @(negedge clock);
      reset      = 1'b0;
      readStrobe = 1'b0;
      @(posedge clock);
      #1;
      tests_run++;
      if (ready1 !== 1'b0 || dataBusOE1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release: ready=%b oe=%b, required 0 0", ready1, dataBusOE1);
      end
   endtask

   task automatic test_write_read();
      int lat; logic [7:0] rd, rd_hold; logic oe_r, rdy_hold, rdy_after, oe_after;
      run_cycle(1'b1, 16'h0010, 8'h5A, lat, rd, oe_r, rdy_hold, rd_hold, rdy_after, oe_after);
      tests_run++;
      if (lat !== 2) begin
         tests_failed++;
         $display("FAIL write_latency: got %0d cycles, required 2", lat);
      end
      tests_run++;
      if (oe_r !== 1'b0) begin
         tests_failed++;
         $display("FAIL write_oe: got %b, required 0", oe_r);
      end
      tests_run++;
      if (rdy_after !== 1'b0) begin
         tests_failed++;
         $display("FAIL write_ready_drop: got %b, required 0", rdy_after);
      end
      run_cycle(1'b0, 16'h0010, 8'h00, lat, rd, oe_r, rdy_hold, rd_hold, rdy_after, oe_after);
      tests_run++;
      if (lat !== 2 || rd !== 8'h5A || oe_r !== 1'b1) begin
         tests_failed++;
         $display("FAIL read_0010: lat=%0d data=%h oe=%b, required 2 5a 1", lat, rd, oe_r);
      end
      tests_run++;
      if (rdy_hold !== 1'b1 || rd_hold !== 8'h5A) begin
         tests_failed++;
         $display("FAIL read_hold: ready=%b data=%h, required 1 5a", rdy_hold, rd_hold);
      end
      tests_run++;
      if (rdy_after !== 1'b0 || oe_after !== 1'b0) begin
         tests_failed++;
         $display("FAIL read_release: ready=%b oe=%b, required 0 0", rdy_after, oe_after);
      end
   endtask

   task automatic test_unmapped();
      int lat; logic [7:0] rd, rd_hold; logic oe_r, rdy_hold, rdy_after, oe_after;
      run_cycle(1'b1, 16'h0000, 8'h3C, lat, rd, oe_r, rdy_hold, rd_hold, rdy_after, oe_after);
      run_cycle(1'b1, 16'h2000, 8'h12, lat, rd, oe_r, rdy_hold, rd_hold, rdy_after, oe_after);
      tests_run++;
      if (lat !== 2) begin
         tests_failed++;
         $display("FAIL unmapped_write_latency: got %0d, required 2", lat);
      end
      run_cycle(1'b0, 16'h2000, 8'h00, lat, rd, oe_r, rdy_hold, rd_hold, rdy_after, oe_after);
      tests_run++;
      if (rd !== 8'hFF || oe_r !== 1'b1) begin
         tests_failed++;
         $display("FAIL unmapped_read_2000: data=%h oe=%b, required ff 1", rd, oe_r);
      end
      run_cycle(1'b0, 16'h0000, 8'h00, lat, rd, oe_r, rdy_hold, rd_hold, rdy_after, oe_after);
      tests_run++;
      if (rd !== 8'h3C) begin
         tests_failed++;
         $display("FAIL read_0000_after_unmapped_write: data=%h, required 3c", rd);
      end
   endtask

   task automatic test_latency();
      int lat0, lat1, lat15;
      lat0 = -1; lat1 = -1; lat15 = -1;
      idle(20);
      @(negedge clock);
      addressBus = 16'h0010;
      readStrobe = 1'b1;
      @(posedge clock);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock);
         #1;
         if (ready0  && lat0  < 0) lat0  = k;
         if (ready1  && lat1  < 0) lat1  = k;
         if (ready15 && lat15 < 0) lat15 = k;
         if (lat0 >= 0 && lat1 >= 0 && lat15 >= 0) break;
      end
      tests_run++;
      if (lat0 !== 1) begin
         tests_failed++;
         $display("FAIL latency_ws0: got %0d, required 1", lat0);
      end
      tests_run++;
      if (lat15 !== 16) begin
         tests_failed++;
         $display("FAIL latency_ws15: got %0d, required 16", lat15);
      end
      tests_run++;
      if (dataBusOut0 !== 8'h5A || dataBusOE0 !== 1'b1) begin
         tests_failed++;
         $display("FAIL ws0_read_data: data=%h oe=%b, required 5a 1", dataBusOut0, dataBusOE0);
      end
      idle(3);
   endtask

   task automatic test_bus_error();
      int lat; logic [7:0] rd, rd_hold; logic oe_r, rdy_hold, rdy_after, oe_after;
      idle(20);
      @(negedge clock);
      readStrobe  = 1'b1;
      writeStrobe = 1'b1;
      @(posedge clock);
      #1;
      tests_run++;
      if (busError1 !== 1'b1 || ready1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL bus_error_pulse: err=%b ready=%b, required 1 0", busError1, ready1);
      end
      @(negedge clock);
      readStrobe  = 1'b0;
      writeStrobe = 1'b0;
      @(posedge clock);
      #1;
      tests_run++;
      if (busError1 !== 1'b0 || ready1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL bus_error_width: err=%b ready=%b, required 0 0", busError1, ready1);
      end
      run_cycle(1'b0, 16'h0010, 8'h00, lat, rd, oe_r, rdy_hold, rd_hold, rdy_after, oe_after);
      tests_run++;
      if (lat !== 2 || rd !== 8'h5A) begin
         tests_failed++;
         $display("FAIL read_after_bus_error: lat=%0d data=%h, required 2 5a", lat, rd);
      end
   endtask

   task automatic test_reset_mid_cycle();
      int lat; logic [7:0] rd, rd_hold; logic oe_r, rdy_hold, rdy_after, oe_after;
      logic saw_ready;
      idle(20);
      run_cycle(1'b1, 16'h0020, 8'h33, lat, rd, oe_r, rdy_hold, rd_hold, rdy_after, oe_after);
      idle(20);
      @(negedge clock);
      addressBus  = 16'h0020;
      dataBusIn   = 8'hA5;
      writeStrobe = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      saw_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         if (ready1) saw_ready = 1'b1;
      end
      @(negedge clock);
      reset       = 1'b0;
      writeStrobe = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock);
         #1;
         if (ready1) saw_ready = 1'b1;
      end
      tests_run++;
      if (saw_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_ready: ready seen=%b, required 0", saw_ready);
      end
      run_cycle(1'b0, 16'h0020, 8'h00, lat, rd, oe_r, rdy_hold, rd_hold, rdy_after, oe_after);
      tests_run++;
      if (rd !== 8'h33 || lat !== 2) begin
         tests_failed++;
         $display("FAIL reset_mid_old_data: data=%h lat=%0d, required 33 2", rd, lat);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_unmapped();
      test_latency();
      test_bus_error();
      test_reset_mid_cycle();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_bus_memory_responder
`default_nettype wire
